// File: rtl/cell_ram_pkg.sv
// Shared types and default constants for the cell RAM arbiter.
package cell_ram_pkg;

  localparam int ADDR_W_DEF     = 24;
  localparam int RD_LAT_DEF     = 2;
  localparam int STARVE_MAX_DEF = 8;

  typedef enum logic [1:0] {
    REQ_LDR,
    REQ_ENG,
    REQ_VGA
  } requester_e;

  typedef struct packed {
    logic       valid;
    requester_e owner;
  } rd_tag_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hffff_ffff) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cell_ram_rd_tag_pipe.sv
// Fixed-depth shift register that carries read ownership alongside the RAM read latency.
module cell_ram_rd_tag_pipe
  import cell_ram_pkg::*;
#(
  parameter int DEPTH = RD_LAT_DEF + 1
) (
  input  logic    clk_ram,
  input  logic    reset,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage [DEPTH];

  always_ff @(posedge clk_ram or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/cell_ram_arbiter.sv
// Single-port cell RAM arbiter for SD loader, life engine and VGA scan-out.
// Define CELL_ARB_STATS_EN to build the per-requester transfer/stall counters.
module cell_ram_arbiter
  import cell_ram_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk_ram,
  input  logic              reset,
  input  logic              load_done,
  input  logic              ldr_req,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic              ldr_wdata,
  output logic              ldr_ready,
  input  logic              eng_req,
  input  logic              eng_we,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic              eng_wdata,
  output logic              eng_ready,
  output logic              eng_rvalid,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_ready,
  output logic              vga_rvalid,
  output logic              rdata,
  output logic              eng_hold,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wdata,
  output logic              ram_wren,
  output logic              ram_rden,
  input  logic              ram_q,
  output logic [31:0]       stat_ldr,
  output logic [31:0]       stat_eng,
  output logic [31:0]       stat_vga,
  output logic [31:0]       stat_stall
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);

  logic [SC_W-1:0]   starve_cnt;
  logic              eng_elig;
  logic              eng_force;
  logic              grant_ldr, grant_eng, grant_vga;
  logic              xfer;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic              win_wdata;
  requester_e        win_owner;
  requester_e        rd_owner;
  rd_tag_t           tag_in, tag_out;

  assign eng_elig  = eng_req && !eng_hold;
  assign eng_force = eng_elig && (starve_cnt == SC_W'(STARVE_MAX));

  // Handshake: a transfer happens on the rising edge where x_req && x_ready; x_ready is
  // combinational from the reqs and registered state, at most one is high, and the
  // requester keeps addr/we/wdata stable while req is high and ready is low.
  always_comb begin
    grant_ldr = 1'b0;
    grant_eng = 1'b0;
    grant_vga = 1'b0;
    if (eng_force)     grant_eng = 1'b1;
    else if (vga_req)  grant_vga = 1'b1;
    else if (ldr_req)  grant_ldr = 1'b1;
    else if (eng_elig) grant_eng = 1'b1;
  end

  assign ldr_ready = grant_ldr;
  assign eng_ready = grant_eng;
  assign vga_ready = grant_vga;
  assign xfer      = grant_ldr || grant_eng || grant_vga;

  always_comb begin
    win_we    = 1'b0;
    win_addr  = vga_addr;
    win_wdata = 1'b0;
    win_owner = REQ_VGA;
    if (grant_ldr) begin
      win_we    = 1'b1;
      win_addr  = ldr_addr;
      win_wdata = ldr_wdata;
      win_owner = REQ_LDR;
    end else if (grant_eng) begin
      win_we    = eng_we;
      win_addr  = eng_addr;
      win_wdata = eng_wdata;
      win_owner = REQ_ENG;
    end
  end

  always_ff @(posedge clk_ram or posedge reset) begin
    if (reset) begin
      eng_hold   <= 1'b1;
      starve_cnt <= '0;
      ram_addr   <= '0;
      ram_wdata  <= 1'b0;
      ram_wren   <= 1'b0;
      ram_rden   <= 1'b0;
      rd_owner   <= REQ_LDR;
      rdata      <= 1'b0;
    end else begin
      eng_hold <= !load_done;
      rdata    <= ram_q;
      ram_wren <= xfer && win_we;
      ram_rden <= xfer && !win_we;
      if (xfer) begin
        ram_addr  <= win_addr;
        ram_wdata <= win_wdata;
        rd_owner  <= win_owner;
      end
      if (!eng_req || grant_eng)
        starve_cnt <= '0;
      else if (eng_elig && starve_cnt != SC_W'(STARVE_MAX))
        starve_cnt <= starve_cnt + SC_W'(1);
    end
  end

  // The pipe starts from the registered read strobe, so its last stage lines up with rdata.
  assign tag_in.valid = ram_rden;
  assign tag_in.owner = rd_owner;

  cell_ram_rd_tag_pipe #(
    .DEPTH(RD_LAT + 1)
  ) u_tag_pipe (
    .clk_ram(clk_ram),
    .reset  (reset),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  assign eng_rvalid = tag_out.valid && (tag_out.owner == REQ_ENG);
  assign vga_rvalid = tag_out.valid && (tag_out.owner == REQ_VGA);

`ifdef CELL_ARB_STATS_EN
  logic load_rise;
  assign load_rise = load_done && eng_hold;

  always_ff @(posedge clk_ram or posedge reset) begin
    if (reset) begin
      stat_ldr   <= '0;
      stat_eng   <= '0;
      stat_vga   <= '0;
      stat_stall <= '0;
    end else if (load_rise) begin
      stat_ldr   <= '0;
      stat_eng   <= '0;
      stat_vga   <= '0;
      stat_stall <= '0;
    end else begin
      if (grant_ldr) stat_ldr <= sat_inc32(stat_ldr);
      if (grant_eng) stat_eng <= sat_inc32(stat_eng);
      if (grant_vga) stat_vga <= sat_inc32(stat_vga);
      if (eng_elig && !grant_eng) stat_stall <= sat_inc32(stat_stall);
    end
  end
`else
  assign stat_ldr   = 32'd0;
  assign stat_eng   = 32'd0;
  assign stat_vga   = 32'd0;
  assign stat_stall = 32'd0;
`endif

endmodule

// File: tb/tb_cell_ram_arbiter.sv
// Bench for cell_ram_arbiter: behavioural RAM + arbitration model and directed scenarios.
module tb_cell_ram_arbiter;

  localparam int ADDR_W     = 24;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 8;

  // ---------------- clock / reset ----------------
  logic clk_ram = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_ram = ~clk_ram;

  logic              load_done, ldr_req, ldr_wdata, ldr_ready;
  logic [ADDR_W-1:0] ldr_addr, eng_addr, vga_addr, ram_addr;
  logic              eng_req, eng_we, eng_wdata, eng_ready, eng_rvalid;
  logic              vga_req, vga_ready, vga_rvalid, rdata, eng_hold;
  logic              ram_wdata, ram_wren, ram_rden, ram_q;
  logic [31:0]       stat_ldr, stat_eng, stat_vga, stat_stall;

  cell_ram_arbiter #(
    .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk_ram(clk_ram), .reset(reset), .load_done(load_done),
    .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ready(ldr_ready),
    .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
    .eng_ready(eng_ready), .eng_rvalid(eng_rvalid),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_ready(vga_ready), .vga_rvalid(vga_rvalid),
    .rdata(rdata), .eng_hold(eng_hold),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_rden(ram_rden),
    .ram_q(ram_q),
    .stat_ldr(stat_ldr), .stat_eng(stat_eng), .stat_vga(stat_vga), .stat_stall(stat_stall)
  );

  // ---------------- RAM stub (RD_LAT cycles from command on pins to data on ram_q) ----------------
  logic mem   [64];
  logic q_pipe[RD_LAT];
  logic tog = 1'b0;

  always @(negedge clk_ram) tog <= ~tog;
  assign ram_q = reset ? tog : q_pipe[RD_LAT-1];

  always @(posedge clk_ram) begin
    if (ram_wren) mem[ram_addr[5:0]] <= ram_wdata;
    q_pipe[0] <= ram_rden ? mem[ram_addr[5:0]] : 1'b0;
    for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: each entry of exp_q is {due_cycle[15:0], is_eng, data}.
  logic [17:0]       exp_q[$];
  logic              m_mem[64];
  int                cyc = 0;
  int                m_starve;
  logic              m_hold, m_wren, m_rden, m_wdata;
  logic [ADDR_W-1:0] m_addr;
  int                g;
  logic              elig, ev, ee, ed;
  logic [17:0]       ent;
  logic [ADDR_W-1:0] w_addr;
`ifdef CELL_ARB_STATS_EN
  logic [31:0] m_sl, m_se, m_sv, m_ss;
`endif

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]   = 1'(i & 1) ^ 1'((i >> 2) & 1);
      m_mem[i] = 1'(i & 1) ^ 1'((i >> 2) & 1);
    end
  end

  always @(negedge clk_ram) begin
    cyc++;
    if (reset) begin
      exp_q.delete();
      m_starve = 0; m_hold = 1'b1;
      m_wren = 1'b0; m_rden = 1'b0; m_wdata = 1'b0; m_addr = '0;
`ifdef CELL_ARB_STATS_EN
      m_sl = 0; m_se = 0; m_sv = 0; m_ss = 0;
`endif
      check("rst_hold", eng_hold, 1);
      check("rst_cmd", {ram_wren, ram_rden}, 0);
      check("rst_addr", ram_addr, 0);
      check("rst_wdata", ram_wdata, 0);
      check("rst_rvalid", {eng_rvalid, vga_rvalid}, 0);
      check("rst_rdata", rdata, 0);
      check("rst_ready", {ldr_ready, eng_ready, vga_ready}, 0);
    end else begin
      elig = eng_req && !m_hold;
      if (elig && m_starve == STARVE_MAX) g = 2;
      else if (vga_req)                   g = 3;
      else if (ldr_req)                   g = 1;
      else if (elig)                      g = 2;
      else                                g = 0;

      check("m_ready", {ldr_ready, eng_ready, vga_ready}, {g == 1, g == 2, g == 3});
      check("m_hold", eng_hold, m_hold);
      check("m_wren", ram_wren, m_wren);
      check("m_rden", ram_rden, m_rden);
      check("m_addr", ram_addr, m_addr);
      if (m_wren) check("m_wdata", ram_wdata, m_wdata);

      ev = 1'b0; ee = 1'b0; ed = 1'b0;
      if (exp_q.size() > 0 && exp_q[0][17:2] == cyc[15:0]) begin
        ent = exp_q.pop_front();
        ee  = ent[1];
        ev  = !ent[1];
        ed  = ent[0];
      end
      check("m_rvalid", {eng_rvalid, vga_rvalid}, {ee, ev});
      if (ee || ev) check("m_rdata", rdata, ed);

`ifdef CELL_ARB_STATS_EN
      check("m_stat_ldr", stat_ldr, m_sl);
      check("m_stat_eng", stat_eng, m_se);
      check("m_stat_vga", stat_vga, m_sv);
      check("m_stat_stall", stat_stall, m_ss);
      if (load_done && m_hold) begin
        m_sl = 0; m_se = 0; m_sv = 0; m_ss = 0;
      end else begin
        if (g == 1) m_sl++;
        if (g == 2) m_se++;
        if (g == 3) m_sv++;
        if (elig && g != 2) m_ss++;
      end
`else
      check("stat_zero", stat_ldr | stat_eng | stat_vga | stat_stall, 0);
`endif

      // advance the model across the coming edge
      if (!eng_req || g == 2) m_starve = 0;
      else if (elig && m_starve < STARVE_MAX) m_starve++;
      m_hold = !load_done;
      m_wren = 1'b0;
      m_rden = 1'b0;
      if (g != 0) begin
        w_addr = (g == 1) ? ldr_addr : (g == 2) ? eng_addr : vga_addr;
        m_addr = w_addr;
        if (g == 1 || (g == 2 && eng_we)) begin
          m_wren  = 1'b1;
          m_wdata = (g == 1) ? ldr_wdata : eng_wdata;
          m_mem[w_addr[5:0]] = m_wdata;
        end else begin
          m_rden = 1'b1;
          exp_q.push_back({16'(cyc + RD_LAT + 2), g == 2, m_mem[w_addr[5:0]]});
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk_ram);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk_ram);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    load_done = 1'b0;
    ldr_req = 1'b0; ldr_addr = '0; ldr_wdata = 1'b0;
    eng_req = 1'b0; eng_we = 1'b0; eng_addr = '0; eng_wdata = 1'b0;
    vga_req = 1'b0; vga_addr = '0;

    // reset with a toggling ram_q and a load in progress
    repeat (3) begin
      at_neg();
      check("t1_hold", eng_hold, 1);
      check("t1_enables", {ram_wren, ram_rden}, 0);
      check("t1_rvalid", {eng_rvalid, vga_rvalid}, 0);
    end
    tick();
    reset = 1'b0;

    // vga beats loader while both request; loader writes once vga drops
    vga_req = 1'b1; vga_addr = 24'd5;
    ldr_req = 1'b1; ldr_addr = 24'd9; ldr_wdata = 1'b1;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      check("t2_vga_ready", vga_ready, 1);
      check("t2_ldr_ready", ldr_ready, 0);
      if (i > 0) check("t2_rd5", {ram_rden, ram_addr}, {1'b1, 24'd5});
      tick();
    end
    vga_req = 1'b0;
    at_neg();
    check("t2_ldr_go", ldr_ready, 1);
    tick();
    ldr_req = 1'b0;
    at_neg();
    check("t2_wr9", {ram_wren, ram_wdata, ram_addr}, {1'b1, 1'b1, 24'd9});
    tick();

    // engine read of addr 3 (content 1), rvalid RD_LAT+1 cycles after transfer
    load_done = 1'b1;
    tick();
    eng_req = 1'b1; eng_we = 1'b0; eng_addr = 24'd3;
    at_neg();
    check("t3_eng_ready", eng_ready, 1);
    tick();
    eng_req = 1'b0;
    at_neg();
    check("t3_rd3", {ram_rden, ram_addr}, {1'b1, 24'd3});
    tick();
    tick();
    at_neg();
    check("t3_early", eng_rvalid, 0);
    tick();
    at_neg();
    check("t3_rvalid", {eng_rvalid, rdata}, 2'b11);
    tick();

    // starvation: eng forced through every 9th cycle against continuous vga
    vga_req = 1'b1; vga_addr = 24'd7;
    eng_req = 1'b1; eng_addr = 24'd2;
    for (int i = 0; i < 27; i++) begin
      at_neg();
      check("t4_eng", eng_ready, (i % 9 == 8) ? 1 : 0);
      check("t4_vga", vga_ready, (i % 9 == 8) ? 0 : 1);
      tick();
    end
    vga_req = 1'b0; eng_req = 1'b0;
    repeat (6) tick();

    // interleaved vga/eng/vga reads at 10, 11, 12 -> data 0, 1, 1
    vga_req = 1'b1; vga_addr = 24'd10;
    tick();
    vga_req = 1'b0; eng_req = 1'b1; eng_addr = 24'd11;
    tick();
    eng_req = 1'b0; vga_req = 1'b1; vga_addr = 24'd12;
    tick();
    vga_req = 1'b0;
    tick();
    at_neg();
    check("t5_first", {vga_rvalid, eng_rvalid, rdata}, 3'b100);
    tick();
    at_neg();
    check("t5_second", {vga_rvalid, eng_rvalid, rdata}, 3'b011);
    tick();
    at_neg();
    check("t5_third", {vga_rvalid, eng_rvalid, rdata}, 3'b101);
    tick();

    // engine write then read back
    eng_req = 1'b1; eng_we = 1'b1; eng_addr = 24'd3; eng_wdata = 1'b0;
    tick();
    eng_we = 1'b0;
    at_neg();
    check("t7_wr3", {ram_wren, ram_wdata, ram_addr}, {1'b1, 1'b0, 24'd3});
    tick();
    eng_req = 1'b0;
    tick();
    tick();
    tick();
    at_neg();
    check("t7_readback", {eng_rvalid, rdata}, 2'b10);
    tick();

    // load starts while two engine reads (12 -> 1, 10 -> 0) are in flight
    eng_req = 1'b1; eng_addr = 24'd12;
    tick();
    eng_addr = 24'd10;
    tick();
    eng_req = 1'b0; load_done = 1'b0;
    at_neg();
    check("t6_hold_lag", eng_hold, 0);
    tick();
    eng_req = 1'b1; eng_addr = 24'd4;
    at_neg();
    check("t6_hold", eng_hold, 1);
    check("t6_blocked", eng_ready, 0);
    tick();
    at_neg();
    check("t6_rv1", {eng_rvalid, rdata}, 2'b11);
    tick();
    at_neg();
    check("t6_rv2", {eng_rvalid, rdata}, 2'b10);
    tick();
    repeat (4) begin
      at_neg();
      check("t6_still_blocked", eng_ready, 0);
      tick();
    end
    load_done = 1'b1;
    at_neg();
    check("t6_hold_until_edge", eng_ready, 0);
    tick();
    at_neg();
    check("t6_released", eng_ready, 1);
    tick();

    // loader serviced after load_done, ahead of the engine
    ldr_req = 1'b1; ldr_addr = 24'd20; ldr_wdata = 1'b1; eng_addr = 24'd21;
    at_neg();
    check("t6_ldr_first", {ldr_ready, eng_ready}, 2'b10);
    tick();
    ldr_req = 1'b0;
    at_neg();
    check("t6_eng_next", {ldr_ready, eng_ready}, 2'b01);
    tick();
    eng_req = 1'b0;
    repeat (5) tick();

    // reset with a read in flight drops its rvalid
    eng_req = 1'b1; eng_addr = 24'd11;
    tick();
    eng_req = 1'b0; reset = 1'b1;
    at_neg();
    check("t8_rst_rv", eng_rvalid, 0);
    tick();
    tick();
    reset = 1'b0;
    at_neg();
    check("t8_hold_after_rst", eng_hold, 1);
    tick();
    repeat (6) begin
      at_neg();
      check("t8_no_rvalid", {eng_rvalid, vga_rvalid}, 0);
      tick();
    end

    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cell_ram_arbiter.md
Name: cell_ram_arbiter

Overview:
Shares the single-port, 1-bit-wide cell RAM between three requesters:
- SD file loader (write-only)
- life-generation engine (read/write)
- VGA scan-out (read-only)

It issues at most one RAM command per clock, routes read data back to the requester that issued the read, and holds the engine off while a file load is in progress. It sits between the three clients and the RAM IP, all on clk_ram.

Parameters:
ADDR_W, 24, RAM word address width (1-bit words)
RD_LAT, 2, RAM read latency in clk_ram cycles (1..4)
STARVE_MAX, 8, consecutive lost eng arbitration cycles before eng is forced to win

Ports:
clk_ram  in  1  RAM-domain clock
reset  in  1  asynchronous active-high reset
load_done  in  1  loader's read_file_finish; 0 = file load in progress
ldr_req  in  1  loader write request
ldr_addr  in  ADDR_W  loader write address
ldr_wdata  in  1  loader write bit
ldr_ready  out  1  loader transfer accepted this cycle
eng_req  in  1  engine request
eng_we  in  1  engine: 1 = write, 0 = read
eng_addr  in  ADDR_W  engine address
eng_wdata  in  1  engine write bit
eng_ready  out  1  engine transfer accepted this cycle
eng_rvalid  out  1  engine read data valid
vga_req  in  1  VGA read request
vga_addr  in  ADDR_W  VGA read address
vga_ready  out  1  VGA transfer accepted this cycle
vga_rvalid  out  1  VGA read data valid
rdata  out  1  registered copy of ram_q, shared by both rvalid strobes
eng_hold  out  1  engine must idle (load in progress)
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  1  RAM write data
ram_wren  out  1  RAM write enable
ram_rden  out  1  RAM read enable
ram_q  in  1  RAM read data
stat_ldr, stat_eng, stat_vga, stat_stall  out  32 each  statistics (see Optional Feature)

Behaviour:
- Handshake: valid/ready. A transfer occurs on a rising edge where x_req && x_ready.
  - x_ready is combinational from the current reqs and registered arbitration state.
  - The requester holds addr/we/wdata stable while req is high and not ready.
  - At most one x_ready is high in any cycle.
- Priority:
  - Normal order is vga > ldr > eng.
  - eng is eligible only when eng_hold = 0.
  - When starve_cnt == STARVE_MAX and eng is eligible and requesting, eng wins over both other requesters for exactly that cycle.
- Starvation counter:
  - starve_cnt increments (saturating at STARVE_MAX) each cycle in which eng_req && !eng_hold && !eng_ready.
  - It clears on an eng transfer, and clears when eng_req = 0.
- Load gating:
  - eng_hold is a registered copy of !load_done; reset value is 1.
  - A load_done 1->0 edge (reload or new file) raises eng_hold on the next cycle.
  - Engine reads already issued still return their eng_rvalid.
- RAM command:
  - Registered on the transfer edge: ram_addr and ram_wdata take the winner's values; ram_wren = winner is a write; ram_rden = winner is a read.
  - With no transfer, ram_wren = ram_rden = 0 and ram_addr/ram_wdata hold their previous values.
- Read return:
  - A tag pipeline of RD_LAT+1 stages carries {valid, owner}.
  - rdata and the matching x_rvalid assert exactly RD_LAT+1 cycles after the transfer edge.
  - Back-to-back reads return in issue order, one per cycle.
  - Writes produce no rvalid.
- Latency: a transfer at edge N puts the command on the RAM pins after edge N, and rvalid appears after edge N+RD_LAT+1.
- Reset values: all *_ready (after reqs settle) = 0, ram_wren = ram_rden = 0, ram_addr = 0, ram_wdata = 0, rdata = 0, both rvalid = 0, eng_hold = 1, starve_cnt = 0, tag pipeline cleared.
- Reset mid-operation: in-flight reads are dropped and no rvalid is issued afterwards.
- ldr_req while load_done = 1 is still serviced, at normal priority.

Optional Feature:
CELL_ARB_STATS_EN
- Defined: stat_ldr/stat_eng/stat_vga count transfers per requester; stat_stall counts cycles with eng_req && !eng_ready && !eng_hold. All four are 32-bit saturating counters, cleared by reset and on each load_done 0->1 edge.
- Undefined: all stat_* outputs are tied to 0 and no counter logic is generated.

Decomposition:
- Package cell_ram_pkg holds:
  - typedef requester_e {REQ_LDR, REQ_ENG, REQ_VGA}
  - typedef rd_tag_t {logic valid; requester_e owner;}
  - default ADDR_W and RD_LAT constants
- One sub-module, cell_ram_rd_tag_pipe: a parameterised (RD_LAT+1)-stage shift register of rd_tag_t with asynchronous clear.

Test Plan:
- Reset with load_done = 0, ram_q toggling -> eng_hold = 1, no ready, no rvalid, all RAM enables 0.
- load_done = 0; ldr_req and vga_req held every cycle, vga_addr = 5, ldr_addr = 9 -> vga wins every cycle, ldr_ready stays 0. Drop vga_req -> ldr writes addr 9 with ram_wren = 1 on the next edge.
- load_done = 1, RD_LAT = 2; eng reads addr 3 (RAM content 1) -> ram_rden at addr 3 after the transfer edge, eng_rvalid = 1 with rdata = 1 exactly 3 cycles after the transfer.
- load_done = 1; vga_req and eng_req held continuously, STARVE_MAX = 8 -> eng_ready asserts on the 9th cycle, then vga resumes winning; pattern repeats every 9 cycles.
- Interleaved vga, eng, vga reads to addrs 10, 11, 12 -> rvalids return in order vga, eng, vga on consecutive cycles with the correct rdata.
- load_done falls while two eng reads are in flight -> both eng_rvalid still return; eng_hold = 1 the next cycle; later eng_req is ignored until load_done rises.
